// File: rtl/fifo_traffic_gen.sv
// Stimulus generator for the FIFO data-integrity harness: N LFSR filler words, one start-tagged magic word, then a drain.
// Optional random bubbles on push/pop when FIFO_TGEN_STALL_EN is defined.
module fifo_traffic_gen #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 8,
  parameter int OCCWID = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [OCCWID-1:0] fill_level,
  input  logic [WIDTH-1:0]  magic_data,
  input  logic [WIDTH-1:0]  seed,
  input  logic              full,
  input  logic              empty,
  output logic              push,
  output logic              pop,
  output logic              start,
  output logic [WIDTH-1:0]  data_in,
  output logic [OCCWID-1:0] occ,
  output logic              magic_pop,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Galois right-shift toggle masks giving maximal-length sequences.
  function automatic logic [31:0] taps_for(input int w);
    case (w)
      2:       return 32'h3;
      3:       return 32'h6;
      4:       return 32'hC;
      5:       return 32'h14;
      6:       return 32'h30;
      7:       return 32'h60;
      8:       return 32'hB8;
      9:       return 32'h110;
      10:      return 32'h240;
      11:      return 32'h500;
      12:      return 32'h829;
      13:      return 32'h100D;
      14:      return 32'h2015;
      15:      return 32'h6000;
      16:      return 32'hD008;
      default: return 32'h80200003;
    endcase
  endfunction

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(taps_for(WIDTH));

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
  endfunction

  typedef enum logic [2:0] {IDLE, FILL, MAGIC, DRAIN, DONE} state_t;

  state_t            state, state_nx;
  logic [OCCWID-1:0] fl;
  logic [OCCWID-1:0] cnt;
  logic [OCCWID-1:0] fl_go;
  logic [WIDTH-1:0]  magic;
  logic [WIDTH-1:0]  lfsr;
  logic              stall;

  assign fl_go = (fill_level > OCCWID'(DEPTH - 1)) ? OCCWID'(DEPTH - 1) : fill_level;

`ifdef FIFO_TGEN_STALL_EN
  logic [WIDTH-1:0] stall_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_lfsr <= WIDTH'(1);
    else if (state == IDLE && go)
      stall_lfsr <= (seed == '1) ? WIDTH'(1) : ~seed;
    else
      stall_lfsr <= lfsr_step(stall_lfsr);
  end

  assign stall = stall_lfsr[0];
`else
  assign stall = 1'b0;
`endif

  // cnt counts filler pushes in FILL and pops in DRAIN; the magic word is pop number fl+1.
  always_comb begin
    state_nx  = state;
    push      = 1'b0;
    pop       = 1'b0;
    start     = 1'b0;
    data_in   = '0;
    magic_pop = 1'b0;
    case (state)
      IDLE: begin
        if (go) state_nx = (fl_go == '0) ? MAGIC : FILL;
      end
      FILL: begin
        push    = ~full & ~stall;
        data_in = (lfsr == magic) ? ~magic : lfsr;
        if (push && cnt == fl - OCCWID'(1)) state_nx = MAGIC;
      end
      MAGIC: begin
        push    = ~full & ~stall;
        start   = push;
        data_in = magic;
        if (push) state_nx = DRAIN;
      end
      DRAIN: begin
        pop = ~empty & ~stall;
        if (pop && cnt == fl) begin
          magic_pop = 1'b1;
          state_nx  = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fl    <= '0;
      cnt   <= '0;
      magic <= '0;
      lfsr  <= WIDTH'(1);
      occ   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && go) begin
        fl    <= fl_go;
        magic <= magic_data;
        lfsr  <= (seed == '0) ? WIDTH'(1) : seed;
        cnt   <= '0;
      end
      if (state == FILL && push) begin
        lfsr <= lfsr_step(lfsr);
        cnt  <= (state_nx == MAGIC) ? '0 : cnt + OCCWID'(1);
      end
      if (state == DRAIN && pop) cnt <= cnt + OCCWID'(1);
      if (push)
        occ <= occ + OCCWID'(1);
      else if (pop)
        occ <= occ - OCCWID'(1);
      if (state != IDLE &&
          ((full != (occ == OCCWID'(DEPTH))) || (empty != (occ == '0))))
        err <= 1'b1;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_fifo_traffic_gen.sv
// Bench for fifo_traffic_gen: an ideal FIFO built from a queue answers full/empty, and the expected
// word stream for each run is derived up front from fill level, seed and magic value.
module tb_fifo_traffic_gen;
  localparam int DEPTH  = 8;
  localparam int WIDTH  = 8;
  localparam int OCCWID = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              go;
  logic [OCCWID-1:0] fill_level;
  logic [WIDTH-1:0]  magic_data;
  logic [WIDTH-1:0]  seed;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              start;
  logic [WIDTH-1:0]  data_in;
  logic [OCCWID-1:0] occ;
  logic              magic_pop;
  logic              busy;
  logic              done;
  logic              err;

  fifo_traffic_gen #(.DEPTH(DEPTH), .WIDTH(WIDTH), .OCCWID(OCCWID)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .fill_level(fill_level), .magic_data(magic_data),
    .seed(seed), .full(full), .empty(empty), .push(push), .pop(pop), .start(start),
    .data_in(data_in), .occ(occ), .magic_pop(magic_pop), .busy(busy), .done(done), .err(err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int                n_cmp = 0;
  int                n_bad = 0;
  logic [WIDTH-1:0]  fifo_q[$];
  logic [WIDTH-1:0]  exp_q[$];
  logic              err_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // x^8+x^6+x^5+x^4+1 stepped as a Galois register: shift right, fold the dropped bit into the taps.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    logic [7:0] nx;
    nx = v >> 1;
    if (v[0]) nx = nx ^ 8'b1011_1000;
    return nx;
  endfunction

  // ---------------- reset ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    go    = 1'b0;
    full  = 1'b0;
    empty = 1'b1;
    #1;
    check("rst_outputs", {push, pop, start, magic_pop, busy, done, err}, 7'b0);
    check("rst_occ", occ, 0);
    fifo_q.delete();
    exp_q.delete();
    err_exp = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  // ---------------- one run ----------------
  // force_at/force_len: hold full high for force_len cycles once force_at words are pushed (-1 = never).
  // abort_at: drop rst_n asynchronously in that run cycle (-1 = never).
  task automatic run(input int fill, input logic [7:0] magic, input logic [7:0] sd,
                     input int force_at, input int force_len, input int abort_at);
    int         fl, cyc, pushes, pops, forced, done_cyc, exp_done;
    bit         got_done, force_now;
    logic [7:0] w, s;
    fl = (fill > DEPTH - 1) ? DEPTH - 1 : fill;
    s  = (sd == 8'd0) ? 8'd1 : sd;
    for (int i = 0; i < fl; i++) begin
      exp_q.push_back((s == magic) ? ~s : s);
      s = lfsr_next(s);
    end
    exp_q.push_back(magic);

    check("idle_busy", busy, 0);
    fill_level = fill[OCCWID-1:0];
    magic_data = magic;
    seed       = sd;
    go         = 1'b1;
    @(posedge clk);
    #1;
    cyc = 1; pushes = 0; pops = 0; forced = 0; done_cyc = 0; got_done = 0;
    while (!got_done && cyc < 400) begin
      check("err", err, err_exp);
      // go and launch inputs must be ignored while busy
      go         = 1'($urandom_range(0, 1));
      fill_level = OCCWID'($urandom_range(0, 15));
      magic_data = 8'($urandom_range(0, 255));
      seed       = 8'($urandom_range(0, 255));
      force_now  = (force_at >= 0 && pops == 0 && pushes == force_at && forced < force_len);
      full  = force_now | (fifo_q.size() == DEPTH);
      empty = (fifo_q.size() == 0);
      #1;
      check("occ", occ, fifo_q.size());
      check("busy", busy, 1);
      check("legal", {push & full, pop & empty, push & pop, start & ~push}, 4'b0);
      if (abort_at == cyc) begin
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {push, pop, start, magic_pop, busy, done, err}, 7'b0);
        check("abort_occ", occ, 0);
        fifo_q.delete();
        exp_q.delete();
        err_exp = 1'b0;
        go = 1'b0; full = 1'b0; empty = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("abort_idle", busy, 0);
        return;
      end
      if (push) begin
        pushes++;
        if (exp_q.size() == 0) check("extra_push", 1, 0);
        else begin
          w = exp_q.pop_front();
          check("data_in", data_in, w);
          check("start", start, exp_q.size() == 0);
        end
        fifo_q.push_back(data_in);
      end
      if (pop && fifo_q.size() > 0) begin
        pops++;
        w = fifo_q.pop_front();
        check("magic_pop", magic_pop, w == magic);
      end else
        check("magic_pop_quiet", magic_pop, 0);
      if (force_now) begin
        forced++;
        err_exp = 1'b1;
      end
      if (done) begin
        got_done = 1;
        done_cyc = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    go = 1'b0;
    check("done_seen", got_done, 1);
    check("push_count", pushes, fl + 1);
    check("pop_count", pops, fl + 1);
    check("words_left", exp_q.size(), 0);
    exp_done = 2 * (fl + 1) + 1 + forced;
`ifdef FIFO_TGEN_STALL_EN
    check("done_not_early", done_cyc >= exp_done, 1);
`else
    check("done_cycle", done_cyc, exp_done);
`endif
    full  = (fifo_q.size() == DEPTH);
    empty = (fifo_q.size() == 0);
    #1;
    check("end_idle", {busy, done}, 2'b00);
    check("end_occ", occ, fifo_q.size());
    check("end_err", err, err_exp);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; go = 1'b0; full = 1'b0; empty = 1'b1;
    fill_level = '0; magic_data = '0; seed = '0; err_exp = 1'b0;
    do_reset();

    run(3,  8'hA5, 8'h01, -1, 0, -1);
    run(12, 8'h77, 8'h2B, -1, 0, -1);
    run(0,  8'h3C, 8'h05, -1, 0, -1);
    run(6,  8'h5A, 8'h11, -1, 0, 2);
    run(3,  8'hA5, 8'h01, -1, 0, -1);
    run(4,  8'h99, 8'h33, 2, 3, -1);
    check("err_sticky", err, 1);
    do_reset();
    check("err_cleared", err, 0);

    for (int k = 0; k < 12; k++)
      run($urandom_range(0, 15), 8'($urandom_range(0, 255)),
          ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255)), -1, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
